// File: rtl/bus_ctl_if.sv
// Bundles the requester handshake and the peripheral bus pins of bus_ctl.
//   slave  : the controller side (samples req/we/addr/wdata/bus_din; drives the rest)
//   master : the environment side (requester plus bussed peripherals)
// NUM_CE sets the width of the active-low chip-enable vector.
interface bus_ctl_if #(
  parameter int unsigned NUM_CE = 4
) ();
  // Requester side
  logic              req;
  logic              we;
  logic [7:0]        addr;
  logic [7:0]        wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [7:0]        rdata;
  // Peripheral bus side
  logic [NUM_CE-1:0] ce_n;
  logic              read_n;
  logic              write_n;
  logic [7:0]        bus_dout;
  logic              bus_oe;
  logic [7:0]        bus_din;

  modport slave (
    input  req, we, addr, wdata, bus_din,
    output ready, done, err, rdata, ce_n, read_n, write_n, bus_dout, bus_oe
  );

  modport master (
    output req, we, addr, wdata, bus_din,
    input  ready, done, err, rdata, ce_n, read_n, write_n, bus_dout, bus_oe
  );
endinterface

// File: rtl/bus_ctl.sv
// Single-transaction sequencer for the shared 8-bit peripheral bus.
// Accepts one read or write at a time over a req/ready handshake and plays it
// out as SETUP -> STROBE -> HOLD with one chip enable low, then pulses done.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bus_ctl_if.slave (request handshake, results, CE/strobes/data pins)
// Every output is a flop; outputs are decoded from the next state so they
// line up with the state they describe.
module bus_ctl #(
  parameter int unsigned NUM_CE     = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic     clk,
  input logic     reset,
  bus_ctl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SetupLd  = (SETUP_CYC  > 0) ? 4'(SETUP_CYC - 1)  : 4'd0;
  localparam logic [3:0] StrobeLd = (STROBE_CYC > 0) ? 4'(STROBE_CYC - 1) : 4'd0;
  localparam logic [3:0] HoldLd   = (HOLD_CYC   > 0) ? 4'(HOLD_CYC - 1)   : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_CE-1:0] ce_n_q, ce_n_d;
  logic              read_n_q, read_n_d;
  logic              write_n_q, write_n_d;
  logic              bus_oe_q, bus_oe_d;
  logic [7:0]        bus_dout_q, bus_dout_d;
  logic              active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          oor_d   = ({24'd0, bus.addr} >= NUM_CE);
          if (oor_d) begin
            // Out-of-range device: complete with err, never touch the bus.
            state_d = StDone;
            cnt_d   = 4'd0;
          end else if (SETUP_CYC != 0) begin
            state_d = StSetup;
            cnt_d   = SetupLd;
          end else begin
            state_d = StStrobe;
            cnt_d   = StrobeLd;
          end
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          // Sample the bus on the edge that ends the strobe.
          if (!we_q) rdata_d = bus.bus_din;
          if (HOLD_CYC != 0) begin
            state_d = StHold;
            cnt_d   = HoldLd;
          end else begin
            state_d = StDone;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    // Output decode from the upcoming state.
    active = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    for (int unsigned i = 0; i < NUM_CE; i++) begin
      ce_n_d[i] = ~(active && (addr_d == 8'(i)));
    end
    read_n_d   = ~((state_d == StStrobe) && !we_d);
    write_n_d  = ~((state_d == StStrobe) && we_d);
    bus_oe_d   = active && we_d;
    bus_dout_d = bus_oe_d ? wdata_d : 8'h00;
    done_d     = (state_d == StDone);
    err_d      = (state_d == StDone) && oor_d;
    ready_d    = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      oor_q      <= 1'b0;
      rdata_q    <= 8'h00;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ce_n_q     <= '1;
      read_n_q   <= 1'b1;
      write_n_q  <= 1'b1;
      bus_oe_q   <= 1'b0;
      bus_dout_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ce_n_q     <= ce_n_d;
      read_n_q   <= read_n_d;
      write_n_q  <= write_n_d;
      bus_oe_q   <= bus_oe_d;
      bus_dout_q <= bus_dout_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.ce_n     = ce_n_q;
  assign bus.read_n   = read_n_q;
  assign bus.write_n  = write_n_q;
  assign bus.bus_oe   = bus_oe_q;
  assign bus.bus_dout = bus_dout_q;

endmodule
